// File: rtl/ntt_pkg.sv
// Shared types and sizing helpers for the iterative multiplier datapath.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package ntt_pkg;

  // Control states of the sequential multiplier
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of shift-and-add steps needed for an n-bit multiplier at k bits per step
  function automatic int step_count(input int n, input int k);
    return n / k;
  endfunction

  // Step counter width; kept at least one bit so a single-step build still has a register
  function automatic int cnt_width(input int n, input int k);
    return ((n / k) > 1) ? $clog2(n / k) : 1;
  endfunction

endpackage

// File: rtl/mult_step.sv
// One radix-2^K shift-and-add step: sum = acc_hi + mcand * digit.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle by the owning FSM.
module mult_step #(
  parameter int N = 16,
  parameter int K = 1
) (
  input  logic [N-1:0]   acc_hi,
  input  logic [N-1:0]   mcand,
  input  logic [K-1:0]   digit,
  output logic [N+K-1:0] sum
);

  logic [N+K-1:0] w_acc;
  logic [N+K-1:0] w_mcand_ext;

  assign w_mcand_ext = {{K{1'b0}}, mcand};

  // Add one shifted copy of the multiplicand per set digit bit; the N+K width cannot overflow
  always_comb begin
    w_acc = {{K{1'b0}}, acc_hi};
    for (int j = 0; j < K; j++) begin
      if (digit[j]) begin
        w_acc = w_acc + (w_mcand_ext << j);
      end
    end
  end

  assign sum = w_acc;

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-and-add N x N multiplier retiring K multiplier bits per cycle; optional
// signed mode under macro MULT_SIGNED_EN. Latency: accept edge + N/K RUN cycles to out_valid.
// Backpressure: p/out_valid held in DONE until out_ready; in_ready low from accept to handshake.
module seq_multiplier
  import ntt_pkg::*;
#(
  parameter int N = 16,
  parameter int K = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
`ifdef MULT_SIGNED_EN
  input  logic           sgn,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p,
  output logic           busy
);

  localparam int             STEPS = step_count(N, K);
  localparam int             CW    = cnt_width(N, K);
  localparam logic [CW-1:0]  LAST  = CW'(STEPS - 1);

  // Reject configurations the datapath cannot represent
  if (N < 2) begin : g_bad_n
    $error("seq_multiplier: N must be at least 2");
  end
  if ((K < 1) || (N % K != 0)) begin : g_bad_k
    $error("seq_multiplier: K must be positive and divide N");
  end

  state_e           r_state;
  logic [N-1:0]     r_mcand;
  logic [N-1:0]     r_mplier;
  logic [N-1:0]     r_acc_hi;
  logic [CW-1:0]    r_cnt;
  logic [2*N-1:0]   r_p;
  logic             r_out_valid;
  logic             r_in_ready;
  logic             r_busy;

  logic [N+K-1:0]   w_sum;
  logic [N+K-1:0]   w_shift_cat;
  logic [N-1:0]     w_mplier_nxt;
  logic [2*N-1:0]   w_prod_raw;
  logic [2*N-1:0]   w_prod_fin;
  logic [N-1:0]     w_a_mag;
  logic [N-1:0]     w_b_mag;
  logic             w_neg_in;

  mult_step #(
    .N (N),
    .K (K)
  ) u_step (
    .acc_hi (r_acc_hi),
    .mcand  (r_mcand),
    .digit  (r_mplier[K-1:0]),
    .sum    (w_sum)
  );

  // Low K bits of the step sum drop into the top of the multiplier as it shifts out;
  // the concatenation form also covers N == K where mplier[N-1:K] would be empty
  assign w_shift_cat  = {w_sum[K-1:0], r_mplier};
  assign w_mplier_nxt = w_shift_cat[N+K-1:K];
  assign w_prod_raw   = {w_sum[N+K-1:K], w_mplier_nxt};

`ifdef MULT_SIGNED_EN
  logic r_neg;

  // Signed operands are reduced to magnitudes at accept; -2^(N-1) maps onto itself, which is its magnitude
  assign w_a_mag    = (sgn && a[N-1]) ? (~a + 1'b1) : a;
  assign w_b_mag    = (sgn && b[N-1]) ? (~b + 1'b1) : b;
  assign w_neg_in   = sgn & (a[N-1] ^ b[N-1]);
  assign w_prod_fin = r_neg ? (~w_prod_raw + 1'b1) : w_prod_raw;

  // Result sign captured with the operands and consumed on DONE entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg <= 1'b0;
    end else if (r_state == IDLE && in_valid) begin
      r_neg <= w_neg_in;
    end
  end
`else
  assign w_a_mag    = a;
  assign w_b_mag    = b;
  assign w_neg_in   = 1'b0;
  assign w_prod_fin = w_prod_raw;
`endif

  // Control FSM with all datapath registers and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc_hi    <= '0;
      r_cnt       <= '0;
      r_p         <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mcand    <= w_a_mag;
            r_mplier   <= w_b_mag;
            r_acc_hi   <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_acc_hi <= w_sum[N+K-1:K];
          r_mplier <= w_mplier_nxt;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            // Product (with any sign fix-up) is registered on the same edge that enters DONE
            r_p         <= w_prod_fin;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign p         = r_p;

endmodule
